// File: rtl/pong_pkg.sv
// Shared definitions for the Pong datapath: game-state encodings, default
// screen geometry and the ball/paddle direction and mode types.
package pong_pkg;

  localparam logic [3:0] ST_NEW_GAME  = 4'b0001;
  localparam logic [3:0] ST_PLAY      = 4'b0010;
  localparam logic [3:0] ST_NEW_BALL  = 4'b0100;
  localparam logic [3:0] ST_GAME_OVER = 4'b1000;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int DEF_COORD_W  = 10;

  typedef enum logic { RIGHT = 1'b0, LEFT = 1'b1 } xdir_t;
  typedef enum logic { UP = 1'b0, DOWN = 1'b1 } ydir_t;

  typedef struct packed {
    xdir_t x;
    ydir_t y;
  } dir_t;

  typedef enum logic [1:0] { GS_NEW_GAME, GS_PLAY, GS_NEW_BALL, GS_GAME_OVER } game_st_t;

  typedef enum logic [1:0] { PAD_HOLD, PAD_CENTRE, PAD_MOVE } pad_mode_t;

  // Anything that is not one of the three live one-hot codes parks the game.
  function automatic game_st_t decode_state(input logic [3:0] s);
    case (s)
      ST_NEW_GAME: return GS_NEW_GAME;
      ST_PLAY:     return GS_PLAY;
      ST_NEW_BALL: return GS_NEW_BALL;
      default:     return GS_GAME_OVER;
    endcase
  endfunction

endpackage

// File: rtl/paddle_ctrl.sv
// One paddle: steps by PADDLE_STEP per motion tick while moving, clamps to the
// playfield, and snaps back to the vertical centre on a new game or ball.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int COORD_W     = DEF_COORD_W,
  parameter int PADDLE_H    = 40,
  parameter int PADDLE_STEP = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_i,
  input  pad_mode_t          mode_i,
  input  logic               up_i,
  input  logic               dn_i,
  output logic [COORD_W-1:0] y_o
);

  localparam int AW = COORD_W + 2;
  localparam logic signed [AW-1:0] Y_MIN  = AW'(PADDLE_H / 2);
  localparam logic signed [AW-1:0] Y_MAX  = AW'(SCREEN_H - 1 - PADDLE_H / 2);
  localparam logic signed [AW-1:0] Y_MID  = AW'(SCREEN_H / 2);
  localparam logic signed [AW-1:0] Y_STEP = AW'(PADDLE_STEP);

  logic signed [AW-1:0] y_q, y_d, y_step;
  logic                 unused_hi;

  always_comb begin
    y_step = y_q;
    if (dn_i && !up_i) begin
      y_step = y_q + Y_STEP;
    end else if (up_i && !dn_i) begin
      y_step = y_q - Y_STEP;
    end

    y_d = y_q;
    if (tick_i) begin
      case (mode_i)
        PAD_CENTRE: y_d = Y_MID;
        PAD_MOVE: begin
          // Signed headroom lets the step go below zero before it is clamped.
          if (y_step < Y_MIN)      y_d = Y_MIN;
          else if (y_step > Y_MAX) y_d = Y_MAX;
          else                     y_d = y_step;
        end
        default: y_d = y_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) y_q <= Y_MID;
    else       y_q <= y_d;
  end

  assign y_o       = y_q[COORD_W-1:0];
  assign unused_hi = ^y_q[AW-1:COORD_W];

endmodule

// File: rtl/pong_motion.sv
// Pong kinematics: motion-tick divider, two clamped paddles and a ball with
// wall bounces, paddle hits (speed-up) and sticky goal flags.
module pong_motion
  import pong_pkg::*;
#(
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int COORD_W     = DEF_COORD_W,
  parameter int BALL_R      = 5,
  parameter int PADDLE_H    = 40,
  parameter int P1_X        = 45,
  parameter int P2_X        = 595,
  parameter int PADDLE_STEP = 2,
  parameter int MAX_SPEED   = 3,
  parameter int TICK_DIV    = 262144,
  localparam int SPEED_W    = $clog2(MAX_SPEED + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         state,
  input  logic               p1_up,
  input  logic               p1_dn,
  input  logic               p2_up,
  input  logic               p2_dn,
  input  logic               serve_dir,
  output logic [COORD_W-1:0] player_1_y,
  output logic [COORD_W-1:0] player_2_y,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic [SPEED_W-1:0] ball_speed,
  output logic               player_1_point,
  output logic               player_2_point,
  output logic               paddle_hit,
  output logic               tick
);

  localparam int AW    = COORD_W + 2;
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef logic signed [AW-1:0] coord_t;

  localparam coord_t X_MID    = coord_t'(SCREEN_W / 2);
  localparam coord_t Y_MID    = coord_t'(SCREEN_H / 2);
  localparam coord_t X_LO     = coord_t'(BALL_R);
  localparam coord_t X_HI     = coord_t'(SCREEN_W - 1 - BALL_R);
  localparam coord_t Y_LO     = coord_t'(BALL_R);
  localparam coord_t Y_HI     = coord_t'(SCREEN_H - 1 - BALL_R);
  localparam coord_t BR       = coord_t'(BALL_R);
  localparam coord_t HALF_H   = coord_t'(PADDLE_H / 2);
  localparam coord_t P1_FACE  = coord_t'(P1_X);
  localparam coord_t P2_FACE  = coord_t'(P2_X);
  localparam coord_t P1_BOUNCE = coord_t'(P1_X + BALL_R);
  localparam coord_t P2_BOUNCE = coord_t'(P2_X - BALL_R);
  localparam dir_t   DIR_RST  = '{x: LEFT, y: UP};

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  game_st_t           gs;
  pad_mode_t          pad_mode;
  logic [COORD_W-1:0] p1_y_w, p2_y_w;

  coord_t             x_q, x_d, y_q, y_d;
  dir_t               dir_q, dir_d;
  logic [SPEED_W-1:0] speed_q, speed_d, speed_inc;
  logic               p1_pt_q, p1_pt_d, p2_pt_q, p2_pt_d;
  logic               hit;

  coord_t             s, p1_y_s, p2_y_s, d1, d2, a1, a2;
  logic               hit1, hit2;
  logic               unused_hi;

  // Motion-tick divider: tick is the last count before the wrap.
  assign tick  = (cnt_q == CNT_W'(TICK_DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign gs = decode_state(state);

  always_comb begin
    pad_mode = PAD_HOLD;
    case (gs)
      GS_NEW_GAME, GS_NEW_BALL: pad_mode = PAD_CENTRE;
      GS_PLAY:                  pad_mode = PAD_MOVE;
      default:                  pad_mode = PAD_HOLD;
    endcase
  end

  paddle_ctrl #(
    .SCREEN_H(SCREEN_H), .COORD_W(COORD_W), .PADDLE_H(PADDLE_H), .PADDLE_STEP(PADDLE_STEP)
  ) u_paddle_1 (
    .clk(clk), .reset(reset), .tick_i(tick), .mode_i(pad_mode),
    .up_i(p1_up), .dn_i(p1_dn), .y_o(p1_y_w)
  );

  paddle_ctrl #(
    .SCREEN_H(SCREEN_H), .COORD_W(COORD_W), .PADDLE_H(PADDLE_H), .PADDLE_STEP(PADDLE_STEP)
  ) u_paddle_2 (
    .clk(clk), .reset(reset), .tick_i(tick), .mode_i(pad_mode),
    .up_i(p2_up), .dn_i(p2_dn), .y_o(p2_y_w)
  );

  // Collision terms use only pre-tick registered ball and paddle values.
  assign s      = coord_t'(speed_q);
  assign p1_y_s = coord_t'(p1_y_w);
  assign p2_y_s = coord_t'(p2_y_w);
  assign d1     = y_q - p1_y_s;
  assign d2     = y_q - p2_y_s;
  assign a1     = d1[AW-1] ? -d1 : d1;
  assign a2     = d2[AW-1] ? -d2 : d2;
  assign hit1   = (x_q - BR > P1_FACE) && (x_q - s - BR <= P1_FACE) && (a1 <= HALF_H);
  assign hit2   = (x_q + BR < P2_FACE) && (x_q + s + BR >= P2_FACE) && (a2 <= HALF_H);

  assign speed_inc = (speed_q >= SPEED_W'(MAX_SPEED)) ? speed_q : speed_q + SPEED_W'(1);

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    speed_d = speed_q;
    p1_pt_d = p1_pt_q;
    p2_pt_d = p2_pt_q;
    hit     = 1'b0;
    if (tick) begin
      case (gs)
        GS_NEW_GAME, GS_NEW_BALL: begin
          x_d     = X_MID;
          y_d     = Y_MID;
          speed_d = SPEED_W'(1);
          dir_d.x = serve_dir ? LEFT : RIGHT;
          dir_d.y = UP;
          p1_pt_d = 1'b0;
          p2_pt_d = 1'b0;
        end
        GS_PLAY: begin
          if (!p1_pt_q && !p2_pt_q) begin
            if (dir_q.y == UP) begin
              if (y_q - s <= Y_LO) begin
                y_d     = Y_LO;
                dir_d.y = DOWN;
              end else begin
                y_d = y_q - s;
              end
            end else begin
              if (y_q + s >= Y_HI) begin
                y_d     = Y_HI;
                dir_d.y = UP;
              end else begin
                y_d = y_q + s;
              end
            end

            // A paddle hit wins over a goal on the same tick.
            if (dir_q.x == LEFT) begin
              if (hit1) begin
                x_d     = P1_BOUNCE;
                dir_d.x = RIGHT;
                speed_d = speed_inc;
                hit     = 1'b1;
              end else if (x_q - s <= X_LO) begin
                x_d     = X_LO;
                p2_pt_d = 1'b1;
              end else begin
                x_d = x_q - s;
              end
            end else begin
              if (hit2) begin
                x_d     = P2_BOUNCE;
                dir_d.x = LEFT;
                speed_d = speed_inc;
                hit     = 1'b1;
              end else if (x_q + s >= X_HI) begin
                x_d     = X_HI;
                p1_pt_d = 1'b1;
              end else begin
                x_d = x_q + s;
              end
            end
          end
        end
        default: begin
          x_d = X_MID;
          y_d = Y_MID;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q     <= X_MID;
      y_q     <= Y_MID;
      dir_q   <= DIR_RST;
      speed_q <= SPEED_W'(1);
      p1_pt_q <= 1'b0;
      p2_pt_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      speed_q <= speed_d;
      p1_pt_q <= p1_pt_d;
      p2_pt_q <= p2_pt_d;
    end
  end

  assign player_1_y     = p1_y_w;
  assign player_2_y     = p2_y_w;
  assign ball_x         = x_q[COORD_W-1:0];
  assign ball_y         = y_q[COORD_W-1:0];
  assign ball_speed     = speed_q;
  assign player_1_point = p1_pt_q;
  assign player_2_point = p2_pt_q;
  assign paddle_hit     = hit;
  assign unused_hi      = ^{x_q[AW-1:COORD_W], y_q[AW-1:COORD_W]};

endmodule

// File: tb/tb_pong_motion.sv
// Directed bench for pong_motion with a 4-cycle motion tick; expected
// positions are hand-derived from the kinematics rules.
module tb_pong_motion;

  localparam logic [3:0] S_NEW_GAME  = 4'b0001;
  localparam logic [3:0] S_PLAY      = 4'b0010;
  localparam logic [3:0] S_NEW_BALL  = 4'b0100;
  localparam logic [3:0] S_GAME_OVER = 4'b1000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] state = S_NEW_BALL;
  logic       p1_up = 1'b0, p1_dn = 1'b0, p2_up = 1'b0, p2_dn = 1'b0;
  logic       serve_dir = 1'b1;
  logic [9:0] player_1_y, player_2_y, ball_x, ball_y;
  logic [1:0] ball_speed;
  logic       player_1_point, player_2_point, paddle_hit, tick;

  int checks = 0;
  int errors = 0;
  int tick_no = 0;
  int hit_count = 0;
  int last_hit_tick = 0;

  pong_motion #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .state(state),
    .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
    .serve_dir(serve_dir),
    .player_1_y(player_1_y), .player_2_y(player_2_y),
    .ball_x(ball_x), .ball_y(ball_y), .ball_speed(ball_speed),
    .player_1_point(player_1_point), .player_2_point(player_2_point),
    .paddle_hit(paddle_hit), .tick(tick)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Driver tasks: called at a falling edge; return at the falling edge after the tick update.
  task automatic step_tick(output logic hit);
    int guard = 0;
    while (tick !== 1'b1 && guard < 16) begin
      @(negedge clk);
      guard++;
    end
    if (tick !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: got no tick within %0d cycles", guard);
    end
    hit = paddle_hit;
    @(negedge clk);
  endtask

  task automatic run_ticks(input int n);
    logic h;
    for (int i = 0; i < n; i++) begin
      step_tick(h);
      tick_no++;
      if (h === 1'b1) begin
        hit_count++;
        last_hit_tick = tick_no;
      end
    end
  endtask

  task automatic serve(input logic dir);
    serve_dir = dir;
    state = S_NEW_BALL;
    run_ticks(1);
    state = S_PLAY;
    tick_no = 0;
    hit_count = 0;
  endtask

  task automatic set_buttons(input logic u1, input logic d1, input logic u2, input logic d2);
    p1_up = u1; p1_dn = d1; p2_up = u2; p2_dn = d2;
  endtask

  // Tests
  task automatic test_reset();
    int n;
    repeat (3) @(negedge clk);
    checks++; if (ball_x !== 10'd320) begin errors++; $display("FAIL rst_ball_x: got %0d expected 320", ball_x); end
    checks++; if (ball_y !== 10'd240) begin errors++; $display("FAIL rst_ball_y: got %0d expected 240", ball_y); end
    checks++; if (player_1_y !== 10'd240 || player_2_y !== 10'd240) begin errors++; $display("FAIL rst_paddles: got %0d/%0d expected 240/240", player_1_y, player_2_y); end
    checks++; if (ball_speed !== 2'd1) begin errors++; $display("FAIL rst_speed: got %0d expected 1", ball_speed); end
    checks++; if ({player_1_point, player_2_point, paddle_hit, tick} !== 4'b0000) begin errors++; $display("FAIL rst_flags: got %b expected 0000", {player_1_point, player_2_point, paddle_hit, tick}); end
    reset = 1'b0;
    n = 0;
    while (tick !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n != 3) begin errors++; $display("FAIL first_tick: got %0d cycles expected 3", n); end
    @(negedge clk);
  endtask

  task automatic test_tick();
    int ticks, moves, bad;
    logic [9:0] prev_x;
    logic was_tick;
    serve(1'b1);
    ticks = 0; moves = 0; bad = 0;
    prev_x = ball_x;
    was_tick = tick;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ball_x !== prev_x) begin
        moves++;
        if (!was_tick) bad++;
      end
      if (tick === 1'b1) ticks++;
      was_tick = tick;
      prev_x = ball_x;
    end
    checks++; if (ticks != 10) begin errors++; $display("FAIL tick_count: got %0d expected 10", ticks); end
    checks++; if (moves != 10 || bad != 0) begin errors++; $display("FAIL tick_gating: got moves %0d offtick %0d expected 10 0", moves, bad); end
    checks++; if (ball_x !== 10'd310) begin errors++; $display("FAIL tick_ball_x: got %0d expected 310", ball_x); end
  endtask

  task automatic test_paddles();
    serve(1'b1);
    set_buttons(1'b0, 1'b1, 1'b1, 1'b1);
    run_ticks(1);
    checks++; if (player_1_y !== 10'd242) begin errors++; $display("FAIL pad_step: got %0d expected 242", player_1_y); end
    run_ticks(108);
    checks++; if (player_1_y !== 10'd458) begin errors++; $display("FAIL pad_109: got %0d expected 458", player_1_y); end
    run_ticks(1);
    checks++; if (player_1_y !== 10'd459) begin errors++; $display("FAIL pad_sat: got %0d expected 459", player_1_y); end
    run_ticks(90);
    checks++; if (player_1_y !== 10'd459) begin errors++; $display("FAIL pad_hold_max: got %0d expected 459", player_1_y); end
    checks++; if (player_2_y !== 10'd240) begin errors++; $display("FAIL pad_both_btn: got %0d expected 240", player_2_y); end
    set_buttons(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_wall_and_goal();
    serve(1'b1);
    run_ticks(235);
    checks++; if (ball_y !== 10'd5 || ball_x !== 10'd85) begin errors++; $display("FAIL wall_235: got (%0d,%0d) expected (85,5)", ball_x, ball_y); end
    run_ticks(1);
    checks++; if (ball_y !== 10'd6) begin errors++; $display("FAIL wall_236: got %0d expected 6", ball_y); end
    run_ticks(78);
    checks++; if (player_2_point !== 1'b0 || ball_x !== 10'd6) begin errors++; $display("FAIL goal_314: got x %0d pt %b expected 6 0", ball_x, player_2_point); end
    run_ticks(1);
    checks++; if (ball_x !== 10'd5 || player_2_point !== 1'b1 || player_1_point !== 1'b0) begin errors++; $display("FAIL goal_315: got x %0d pts %b%b expected 5 01", ball_x, player_1_point, player_2_point); end
    run_ticks(2);
    checks++; if (ball_x !== 10'd5 || ball_y !== 10'd85 || player_2_point !== 1'b1) begin errors++; $display("FAIL goal_frozen: got (%0d,%0d) pt %b expected (5,85) 1", ball_x, ball_y, player_2_point); end
    checks++; if (hit_count != 0) begin errors++; $display("FAIL goal_no_hit: got %0d hits expected 0", hit_count); end
    state = S_NEW_BALL;
    run_ticks(1);
    checks++; if (player_2_point !== 1'b0 || ball_x !== 10'd320 || ball_y !== 10'd240 || ball_speed !== 2'd1) begin errors++; $display("FAIL new_ball: got (%0d,%0d) spd %0d pt %b expected (320,240) 1 0", ball_x, ball_y, ball_speed, player_2_point); end
  endtask

  task automatic test_paddle_hit();
    serve(1'b1);
    set_buttons(1'b1, 1'b0, 1'b0, 1'b0);
    run_ticks(109);
    checks++; if (player_1_y !== 10'd22) begin errors++; $display("FAIL hit_pad_109: got %0d expected 22", player_1_y); end
    run_ticks(1);
    checks++; if (player_1_y !== 10'd20) begin errors++; $display("FAIL hit_pad_min: got %0d expected 20", player_1_y); end
    run_ticks(160);
    checks++; if (hit_count != 1 || last_hit_tick != 270) begin errors++; $display("FAIL hit_pulse: got %0d hits at %0d expected 1 at 270", hit_count, last_hit_tick); end
    checks++; if (ball_x !== 10'd50 || ball_y !== 10'd40) begin errors++; $display("FAIL hit_pos: got (%0d,%0d) expected (50,40)", ball_x, ball_y); end
    checks++; if (ball_speed !== 2'd2) begin errors++; $display("FAIL hit_speed: got %0d expected 2", ball_speed); end
    run_ticks(1);
    checks++; if (ball_x !== 10'd52 || hit_count != 1 || player_2_point !== 1'b0) begin errors++; $display("FAIL hit_after: got x %0d hits %0d expected 52 1", ball_x, hit_count); end
    set_buttons(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_speed_ramp();
    int exp_tick [4];
    int exp_speed [4];
    int exp_x [4];
    exp_tick  = '{270, 135, 90, 90};
    exp_speed = '{2, 3, 3, 3};
    exp_x     = '{590, 50, 590, 50};
    serve(1'b0);
    set_buttons(1'b0, 1'b1, 1'b1, 1'b0);
    for (int r = 0; r < 4; r++) begin
      tick_no = 0;
      hit_count = 0;
      while (hit_count == 0 && tick_no < exp_tick[r] + 20) run_ticks(1);
      checks++; if (hit_count != 1 || last_hit_tick != exp_tick[r]) begin errors++; $display("FAIL ramp_hit_%0d: got %0d hits at %0d expected 1 at %0d", r, hit_count, last_hit_tick, exp_tick[r]); end
      checks++; if (ball_speed !== 2'(exp_speed[r])) begin errors++; $display("FAIL ramp_speed_%0d: got %0d expected %0d", r, ball_speed, exp_speed[r]); end
      checks++; if (ball_x !== 10'(exp_x[r])) begin errors++; $display("FAIL ramp_x_%0d: got %0d expected %0d", r, ball_x, exp_x[r]); end
      state = S_GAME_OVER;
      run_ticks(1);
      state = S_PLAY;
    end
  endtask

  task automatic test_game_over();
    state = S_GAME_OVER;
    set_buttons(1'b1, 1'b0, 1'b0, 1'b1);
    run_ticks(3);
    checks++; if (player_1_y !== 10'd459 || player_2_y !== 10'd20) begin errors++; $display("FAIL go_paddles: got %0d/%0d expected 459/20", player_1_y, player_2_y); end
    checks++; if (ball_x !== 10'd320 || ball_y !== 10'd240 || ball_speed !== 2'd3) begin errors++; $display("FAIL go_ball: got (%0d,%0d) spd %0d expected (320,240) 3", ball_x, ball_y, ball_speed); end
    state = 4'b0011;
    run_ticks(2);
    checks++; if (player_1_y !== 10'd459 || player_2_y !== 10'd20 || ball_x !== 10'd320 || ball_y !== 10'd240) begin errors++; $display("FAIL go_bad_state: got p %0d/%0d ball (%0d,%0d) expected 459/20 (320,240)", player_1_y, player_2_y, ball_x, ball_y); end
    set_buttons(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    state = S_PLAY;
    run_ticks(5);
    checks++; if (ball_x !== 10'd335 || ball_y !== 10'd225 || ball_speed !== 2'd3) begin errors++; $display("FAIL mid_pre: got (%0d,%0d) spd %0d expected (335,225) 3", ball_x, ball_y, ball_speed); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (ball_x !== 10'd320 || ball_y !== 10'd240) begin errors++; $display("FAIL mid_rst_ball: got (%0d,%0d) expected (320,240)", ball_x, ball_y); end
    checks++; if (player_1_y !== 10'd240 || player_2_y !== 10'd240 || ball_speed !== 2'd1) begin errors++; $display("FAIL mid_rst_misc: got p %0d/%0d spd %0d expected 240/240 1", player_1_y, player_2_y, ball_speed); end
    checks++; if (player_1_point !== 1'b0 || player_2_point !== 1'b0) begin errors++; $display("FAIL mid_rst_pts: got %b%b expected 00", player_1_point, player_2_point); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Sequence and report
  initial begin
    test_reset();
    test_tick();
    test_paddles();
    test_wall_and_goal();
    test_paddle_hit();
    test_speed_ramp();
    test_game_over();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
